uart_tx_burst_sender: RTL and testbench



---
 rtl/uart_tx_burst_sender.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_burst_sender.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_burst_sender.sv
// Sends a burst of identical UART frames with a programmable idle gap between frames.
// Define UART_PARITY_EN to add an even-parity bit (8E1, 11 bit times); default is 8N1.
module uart_tx_burst_sender #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int DELAY_UNIT_CLKS = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  data,
  input  logic [14:0] bytes_to_send,
  input  logic [7:0]  delay,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [14:0] bytes_sent
);

  localparam int BIT_W = $clog2(CLKS_PER_BIT);
  localparam int GAP_W = $clog2(255 * DELAY_UNIT_CLKS + 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
`ifdef UART_PARITY_EN
    PARITY_BIT,
`endif
    STOP_BIT,
    GAP,
    FINISH
  } state_e;

  state_e            state_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        data_q;
  logic [7:0]        delay_q;
  logic [14:0]       n_q;
  logic [14:0]       sent_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;

  logic [GAP_W-1:0]  gap_load;
  logic              last_frame;

  assign gap_load   = GAP_W'(int'(delay_q) * DELAY_UNIT_CLKS - 1);
  assign last_frame = (sent_q + 15'd1) == n_q;

  // NOTE: sequential state is updated only with non-blocking (<=) assignments so every
  // register in this block samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      delay_q   <= '0;
      n_q       <= '0;
      sent_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            data_q  <= data;
            n_q     <= bytes_to_send;
            delay_q <= delay;
            sent_q  <= '0;
            busy_q  <= 1'b1;
            if (bytes_to_send == 15'd0) begin
              state_q <= FINISH;
            end else begin
              state_q   <= START_BIT;
              tx_q      <= 1'b0;
              bit_cnt_q <= BIT_LOAD;
            end
          end
        end
        START_BIT: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_q <= bit_cnt_q - BIT_W'(1);
          end else begin
            state_q   <= DATA_BITS;
            tx_q      <= data_q[0];
            bit_idx_q <= '0;
            bit_cnt_q <= BIT_LOAD;
          end
        end
        DATA_BITS: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_q <= bit_cnt_q - BIT_W'(1);
          end else if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_q <= PARITY_BIT;
            tx_q    <= ^data_q;
`else
            state_q <= STOP_BIT;
            tx_q    <= 1'b1;
`endif
            bit_cnt_q <= BIT_LOAD;
          end else begin
            bit_idx_q <= bit_idx_q + 3'd1;
            tx_q      <= data_q[bit_idx_q + 3'd1];
            bit_cnt_q <= BIT_LOAD;
          end
        end
`ifdef UART_PARITY_EN
        PARITY_BIT: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_q <= bit_cnt_q - BIT_W'(1);
          end else begin
            state_q   <= STOP_BIT;
            tx_q      <= 1'b1;
            bit_cnt_q <= BIT_LOAD;
          end
        end
`endif
        STOP_BIT: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_q <= bit_cnt_q - BIT_W'(1);
          end else begin
            sent_q <= sent_q + 15'd1;
            if (last_frame) begin
              state_q <= FINISH;
            end else if (delay_q == 8'd0) begin
              // Back-to-back frames: the next start bit follows the stop bit directly.
              state_q   <= START_BIT;
              tx_q      <= 1'b0;
              bit_cnt_q <= BIT_LOAD;
            end else begin
              state_q   <= GAP;
              gap_cnt_q <= gap_load;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end else begin
            state_q   <= START_BIT;
            tx_q      <= 1'b0;
            bit_cnt_q <= BIT_LOAD;
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bytes_sent = sent_q;

endmodule

// File: tb/tb_uart_tx_burst_sender.sv
// Scoreboard bench for uart_tx_burst_sender: the driver expands each burst into the
// per-cycle line/status sequence it should produce; a negedge monitor pops and compares.
module tb_uart_tx_burst_sender;

  localparam int CPB = 4;
  localparam int DUC = 2;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  data;
  logic [14:0] bytes_to_send;
  logic [7:0]  delay;
  logic        tx;
  logic        busy;
  logic        done;
  logic [14:0] bytes_sent;

  uart_tx_burst_sender #(
    .CLKS_PER_BIT   (CPB),
    .DELAY_UNIT_CLKS(DUC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .data         (data),
    .bytes_to_send(bytes_to_send),
    .delay        (delay),
    .tx           (tx),
    .busy         (busy),
    .done         (done),
    .bytes_sent   (bytes_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tx;
    logic        busy;
    logic        done;
    logic [14:0] sent;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  int   model_sent = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic rec_t mk(input logic t, input logic b, input logic d, input int s);
    rec_t r;
    r.tx   = t;
    r.busy = b;
    r.done = d;
    r.sent = 15'(s);
    return r;
  endfunction

  // Expected line/status for every cycle from the start-sampling edge to the done pulse.
  function automatic int push_burst(input logic [7:0] d, input int n, input int dl);
    logic fb[$];
    int   cnt = 0;
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(d[i]);
`ifdef UART_PARITY_EN
    fb.push_back(^d);
`endif
    fb.push_back(1'b1);
    for (int k = 0; k < n; k++) begin
      foreach (fb[i]) begin
        for (int c = 0; c < CPB; c++) begin
          exp_q.push_back(mk(fb[i], 1'b1, 1'b0, k));
          cnt++;
        end
      end
      if (k < n - 1) begin
        for (int g = 0; g < dl * DUC; g++) begin
          exp_q.push_back(mk(1'b1, 1'b1, 1'b0, k + 1));
          cnt++;
        end
      end
    end
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, n));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, n));
    return cnt + 2;
  endfunction

  // Called just after a rising edge. spur_j: 0 none, -1 random, else edge index of a
  // second start pulse that must be ignored. Burst inputs are scrambled while busy.
  task automatic run_burst(input logic [7:0] d, input int n, input int dl, input int spur_j);
    int r;
    int sj;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, model_sent));
    r  = push_burst(d, n, dl);
    sj = (spur_j < 0) ? int'($urandom_range(1, r - 1)) : spur_j;
    start = 1'b1; data = d; bytes_to_send = 15'(n); delay = 8'(dl);
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 1; j < r; j++) begin
      data = 8'($urandom); bytes_to_send = 15'($urandom); delay = 8'($urandom);
      if (j == sj) begin
        start = 1'b1;
        if (spur_j > 0) data = 8'hFF;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    model_sent = n;
  endtask

  // Reset is sampled k+1 edges after the start edge; the scoreboard drops the
  // abandoned remainder of the burst.
  task automatic run_reset_burst(input logic [7:0] d, input int n, input int k);
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, model_sent));
    void'(push_burst(d, n, 0));
    start = 1'b1; data = d; bytes_to_send = 15'(n); delay = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (k) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    model_sent = 0;
  endtask

  initial begin : monitor
    rec_t e;
    int   cyc = 0;
    int   last_sent = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = mk(1'b1, 1'b0, 1'b0, last_sent);
        last_sent = int'(e.sent);
        check($sformatf("cycle %0d {tx,busy,done,bytes_sent}", cyc),
              32'({tx, busy, done, bytes_sent}), 32'(e));
      end
      cyc++;
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    reset = 1'b1; start = 1'b0; data = '0; bytes_to_send = '0; delay = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;

    run_burst(8'hA5, 1, 0, 0);
    run_burst(8'h3C, 3, 0, 0);
    run_burst(8'h01, 2, 5, 0);
    run_burst(8'h00, 0, 0, 0);
    run_burst(8'h00, 0, 0, 1);
    run_burst(8'h55, 2, 0, 10);
    run_burst(8'h55, 1, 1, FRAME_CYC);
    run_reset_burst(8'h96, 10, FRAME_CYC + 4 + 9);
    run_burst(8'h6B, 1, 0, 0);

    for (int t = 0; t < 24; t++) begin
      run_burst(8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1) ? -1 : 0);
    end

    repeat (4) begin
      @(posedge clk); #1;
    end
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
